// File: rtl/keypad_multitap.sv
// keypad_multitap: 4x4 matrix keypad scanner with debounce and phone-style
// multi-tap letter entry (keys 0..7 carry ABC..WXYZ, key 12 commits the
// pending letter, key 13 clears it, key 14 submits the word).
// Optional feature: define MULTITAP_TIMEOUT_EN to close an open tap chain
// after TAP_TIMEOUT idle cycles; without it no tap counter is built.
module keypad_multitap #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int TAP_TIMEOUT    = 10_000_000
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [7:0] pend_letter,
  output logic       pend_valid,
  output logic [7:0] letter,
  output logic       letter_strobe,
  output logic       word_strobe,
  output logic       key_err
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_TARGET = DB_W'(DEBOUNCE_SCANS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] TAP  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [3:0] KEY_SUBMIT_LETTER = 4'd12;
  localparam logic [3:0] KEY_CLEAR         = 4'd13;
  localparam logic [3:0] KEY_SUBMIT_WORD   = 4'd14;

  // First ASCII letter printed on each letter key.
  function automatic logic [7:0] group_first(input logic [2:0] g);
    logic [7:0] l;
    case (g)
      3'd0:    l = 8'h41;  // A
      3'd1:    l = 8'h44;  // D
      3'd2:    l = 8'h47;  // G
      3'd3:    l = 8'h4A;  // J
      3'd4:    l = 8'h4D;  // M
      3'd5:    l = 8'h50;  // P
      3'd6:    l = 8'h54;  // T
      default: l = 8'h57;  // W
    endcase
    return l;
  endfunction

  // Last ASCII letter printed on each letter key; the chain wraps after it.
  function automatic logic [7:0] group_last(input logic [2:0] g);
    logic [7:0] l;
    case (g)
      3'd0:    l = 8'h43;  // C
      3'd1:    l = 8'h46;  // F
      3'd2:    l = 8'h49;  // I
      3'd3:    l = 8'h4C;  // L
      3'd4:    l = 8'h4F;  // O
      3'd5:    l = 8'h53;  // S
      3'd6:    l = 8'h56;  // V
      default: l = 8'h5A;  // Z
    endcase
    return l;
  endfunction

  logic [3:0]       row_meta;
  logic [3:0]       row_sync;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col_idx;
  logic             dwell_end;
  logic             scan_done;

  logic             col_hit;
  logic [1:0]       col_row;
  logic [3:0]       col_k;
  logic             scan_hit;
  logic [3:0]       scan_k;
  logic             merged_hit;
  logic [3:0]       merged_k;
  logic [4:0]       scan_res;

  logic [4:0]       cand;
  logic [DB_W-1:0]  db_cnt;
  logic [DB_W-1:0]  next_cnt;
  logic [4:0]       stable;
  logic             press;
  logic [3:0]       press_k;

  logic             is_letter;
  logic             is_submit;
  logic             is_clear;
  logic             is_word;

  logic [1:0]       state;
  logic [2:0]       cur_group;

  assign dwell_end = (div_cnt == DIV_LAST);
  assign scan_done = dwell_end && (col_idx == 2'd3);
  assign col       = 4'b0001 << col_idx;

  // Two-flop synchroniser for the asynchronous row lines.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      row_meta <= 4'd0;
      row_sync <= 4'd0;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // Dwell counter and column rotation: each column is driven SCAN_DIV cycles.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      div_cnt <= '0;
      col_idx <= 2'd0;
    end else if (dwell_end) begin
      div_cnt <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Lowest active row in the current column gives the candidate key index.
  always_comb begin
    col_hit = |row_sync;
    col_row = 2'd0;
    if (row_sync[0])      col_row = 2'd0;
    else if (row_sync[1]) col_row = 2'd1;
    else if (row_sync[2]) col_row = 2'd2;
    else if (row_sync[3]) col_row = 2'd3;
    col_k = {col_row, col_idx};
  end

  // Merge this column's sample with the scan so far, keeping the lowest k.
  always_comb begin
    merged_hit = scan_hit;
    merged_k   = scan_k;
    if (col_idx == 2'd0) begin
      merged_hit = col_hit;
      merged_k   = col_hit ? col_k : 4'd0;
    end else if (col_hit && (!scan_hit || (col_k < scan_k))) begin
      merged_hit = 1'b1;
      merged_k   = col_k;
    end
    scan_res = {merged_hit, merged_k};
  end

  // Hold the partial scan result between column dwells.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      scan_hit <= 1'b0;
      scan_k   <= 4'd0;
    end else if (dwell_end) begin
      scan_hit <= merged_hit;
      scan_k   <= merged_k;
    end
  end

  // Run length of identical full-scan results, saturating at the target.
  always_comb begin
    if (scan_res == cand) begin
      next_cnt = (db_cnt == DB_TARGET) ? db_cnt : db_cnt + DB_W'(1);
    end else begin
      next_cnt = DB_W'(1);
    end
  end

  // Debounce: accept a result after enough identical scans, pulse on new key.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cand    <= 5'd0;
      db_cnt  <= '0;
      stable  <= 5'd0;
      press   <= 1'b0;
      press_k <= 4'd0;
    end else begin
      press <= 1'b0;
      if (scan_done) begin
        cand   <= scan_res;
        db_cnt <= next_cnt;
        if ((next_cnt == DB_TARGET) && (scan_res != stable)) begin
          stable  <= scan_res;
          press   <= scan_res[4];
          press_k <= scan_res[3:0];
        end
      end
    end
  end

  assign is_letter = press && !press_k[3];
  assign is_submit = press && (press_k == KEY_SUBMIT_LETTER);
  assign is_clear  = press && (press_k == KEY_CLEAR);
  assign is_word   = press && (press_k == KEY_SUBMIT_WORD);

`ifdef MULTITAP_TIMEOUT_EN
  localparam int TO_W = $clog2(TAP_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TAP_TIMEOUT);

  logic [TO_W-1:0] tap_cnt;
  logic            timed_out;

  assign timed_out = (tap_cnt == TO_MAX);

  // Idle-cycle counter since the last letter tap, saturating at the timeout.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      tap_cnt <= '0;
    end else if (is_letter) begin
      tap_cnt <= '0;
    end else if (!timed_out) begin
      tap_cnt <= tap_cnt + TO_W'(1);
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TAP_TIMEOUT > 0);
`endif

  // Multi-tap FSM: builds the pending letter and issues the one-cycle strobes.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state         <= IDLE;
      cur_group     <= 3'd0;
      pend_letter   <= 8'h00;
      pend_valid    <= 1'b0;
      letter        <= 8'h00;
      letter_strobe <= 1'b0;
      word_strobe   <= 1'b0;
      key_err       <= 1'b0;
    end else begin
      letter_strobe <= 1'b0;
      word_strobe   <= 1'b0;
      key_err       <= 1'b0;
      if (is_letter) begin
        if ((state == TAP) && (cur_group == press_k[2:0])) begin
          if (pend_letter == group_last(cur_group)) begin
            pend_letter <= group_first(cur_group);
          end else begin
            pend_letter <= pend_letter + 8'd1;
          end
        end else begin
          pend_letter <= group_first(press_k[2:0]);
          cur_group   <= press_k[2:0];
        end
        pend_valid <= 1'b1;
        state      <= TAP;
      end else if (is_submit) begin
        if ((state == TAP) || (state == HOLD)) begin
          letter        <= pend_letter;
          letter_strobe <= 1'b1;
          pend_valid    <= 1'b0;
          state         <= IDLE;
        end else begin
          key_err <= 1'b1;
        end
      end else if (is_clear) begin
        pend_valid <= 1'b0;
        state      <= IDLE;
      end else if (is_word) begin
        word_strobe <= 1'b1;
      end else begin
`ifdef MULTITAP_TIMEOUT_EN
        if ((state == TAP) && timed_out) begin
          state <= HOLD;
        end
`endif
      end
    end
  end

endmodule

// File: doc/keypad_multitap.md
KEYPAD_MULTITAP -- requirements
Module: keypad_multitap

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clock cycles each column is driven.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4: consecutive identical full scans needed to accept a press or release.
REQ-003 SHALL have parameter TAP_TIMEOUT, default 10_000_000: idle cycles after which a tap chain ends.
REQ-004 SHALL have port clk  in  1  system clock, rising edge.
REQ-005 SHALL have port nRst  in  1  asynchronous active-low reset.
REQ-006 SHALL have port row  in  4  keypad row lines, active-high, asynchronous to clk.
REQ-007 SHALL have port col  out  4  one-hot column drive.
REQ-008 SHALL have port pend_letter  out  8  ASCII of the letter currently being tapped.
REQ-009 SHALL have port pend_valid  out  1  pend_letter holds a letter.
REQ-010 SHALL have port letter  out  8  committed ASCII letter.
REQ-011 SHALL have port letter_strobe  out  1  one-cycle pulse, letter is valid.
REQ-012 SHALL have port word_strobe  out  1  one-cycle pulse, submit-word key pressed.
REQ-013 SHALL have port key_err  out  1  one-cycle pulse, submit-letter with nothing pending.

Function
REQ-014 Scanner: col rotates 0001->0010->0100->1000->0001, advancing every SCAN_DIV cycles; row passes a 2-flop synchroniser and is sampled in the last cycle of each column dwell.
REQ-015 Key index k = 4*r + c, r = set row bit position (bit0 = R0), c = driven column position; several bits set in one scan -> lowest k wins.
REQ-016 Debounce: the same k (or "no key") seen in DEBOUNCE_SCANS consecutive full 4-column scans is accepted; press event is a single-cycle internal pulse on the none->k transition; holding a key yields no repeat; a k->k' change with no release counts as release then press of k'.
REQ-017 Key map: k0 ABC, k1 DEF, k2 GHI, k3 JKL, k4 MNO, k5 PQRS, k6 TUV, k7 WXYZ (uppercase ASCII), k12 submit-letter, k13 clear, k14 submit-word, all other k ignored.
REQ-018 FSM states IDLE (no pending), TAP (pending, chain open), HOLD (pending, chain closed).
REQ-019 Letter key in IDLE or HOLD, or different letter key in TAP: pend_letter = first letter of that key, state TAP, tap counter zeroed.
REQ-020 Same letter key in TAP: pend_letter advances to next letter of the group, wrapping from last to first (C->A, S->P, Z->W); tap counter zeroed.
REQ-021 Submit-letter in TAP or HOLD: letter = pend_letter and letter_strobe high exactly one cycle after the press event; pend_valid cleared the same cycle; state IDLE.
REQ-022 Submit-letter in IDLE: key_err pulses one cycle; letter unchanged.
REQ-023 Clear: pend_valid = 0, state IDLE, no strobe.
REQ-024 Submit-word: word_strobe pulses one cycle after the press event in any state; pending letter is not committed and is left unchanged.
REQ-025 pend_letter and pend_valid update one cycle after the press event; letter holds its value until the next commit.
REQ-026 Tap counter saturates; reaching TAP_TIMEOUT in TAP moves the FSM to HOLD, keeping pend_letter.
REQ-027 At most one of letter_strobe, word_strobe, key_err is high in any cycle.

Reset
REQ-028 While nRst = 0: col = 4'b0001, pend_letter = 8'h00, pend_valid = 0, letter = 8'h00, all strobes 0, FSM IDLE, debounce and scan counters and synchronisers cleared.
REQ-029 Reset asserted mid-scan, mid-debounce or mid-chain discards all partial state; a key still held at reset release is reported as a fresh press after debounce.

Configuration
REQ-030 Macro MULTITAP_TIMEOUT_EN: when defined, REQ-026 applies. When undefined, no tap counter is built, HOLD is unreachable, and a chain ends only on a different letter key, submit, or clear.

Verification
REQ-031 With SCAN_DIV=4 and DEBOUNCE_SCANS=2: hold k0, release, then press k12 -> one letter_strobe with letter = 8'h41 ('A'), pend_valid = 0.
REQ-032 Tap k5 five times, then k12 -> pend_letter steps P,Q,R,S,P; committed letter = 8'h50.
REQ-033 Row glitch of one dwell on k1 -> no pend_valid change; k12 with nothing pending -> key_err pulse, no letter_strobe.
REQ-034 With MULTITAP_TIMEOUT_EN and TAP_TIMEOUT=50: tap k2, idle 60 cycles, tap k2 -> pend_letter = 'G', not 'H'; without the macro the same stimulus gives 'H'.
REQ-035 Tap k4 twice, press k14 -> word_strobe pulse, pend_letter stays 'N'; then k13 -> pend_valid = 0.
REQ-036 Assert nRst while k3 is held mid-chain -> all outputs at reset values; after release, 'J' appears following debounce.
